// File: rtl/i2c_arb_pkg.sv
// Shared types and sizes for the two-requester I2C command arbiter.
package i2c_arb_pkg;

    localparam int unsigned NREQ  = 2;
    localparam int unsigned AW    = 7;
    localparam int unsigned DW    = 8;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// Requester command/response bus plus I2C master command/status bus.
interface i2c_req_arbiter_if;
    import i2c_arb_pkg::*;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_rw;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_nack;
    logic               rsp_timeout;
    logic               m_start;
    logic               m_abort;
    logic               m_rw;
    logic [AW-1:0]      m_addr;
    logic [DW-1:0]      m_wdata;
    logic               m_busy;
    logic               m_done;
    logic               m_nack;
    logic [DW-1:0]      m_rdata;

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata,
        input  m_busy, m_done, m_nack, m_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout,
        output m_start, m_abort, m_rw, m_addr, m_wdata
    );

    modport master (
        output req_valid, req_rw, req_addr, req_wdata,
        output m_busy, m_done, m_nack, m_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout,
        input  m_start, m_abort, m_rw, m_addr, m_wdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; priority flips away from whoever was last granted.
module rr_arb2
    import i2c_arb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_grant,
    output logic            o_win_c,
    output logic            o_any_c
);

    logic r_prio;

    always_comb begin
        o_any_c = |i_req;
        if (i_req[0] && i_req[1]) begin
            o_win_c = r_prio;
        end else begin
            o_win_c = i_req[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (i_grant) begin
            r_prio <= ~o_win_c;
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Serialises two requesters onto one I2C master, with a per-transaction
// watchdog that aborts the master if it never reports done.
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter logic [CNT_W-1:0] TIMEOUT = 16'd50000
) (
    input  logic              clk,
    input  logic              rst,
    i2c_req_arbiter_if.slave  bus
);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_owner, w_owner_nxt;
    cmd_t             r_cmd, w_cmd_nxt;
    logic [NREQ-1:0]  r_req_ready, w_req_ready_nxt;
    logic [NREQ-1:0]  r_rsp_valid, w_rsp_valid_nxt;
    logic [DW-1:0]    r_rsp_rdata, w_rsp_rdata_nxt;
    logic             r_rsp_nack, w_rsp_nack_nxt;
    logic             r_rsp_timeout, w_rsp_timeout_nxt;
    logic             r_m_start, w_m_start_nxt;
    logic             r_m_abort, w_m_abort_nxt;
    logic             w_grant;
    logic             w_win;
    logic             w_any;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .i_req   (bus.req_valid),
        .i_grant (w_grant),
        .o_win_c (w_win),
        .o_any_c (w_any)
    );

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_owner_nxt       = r_owner;
        w_cmd_nxt         = r_cmd;
        w_req_ready_nxt   = '0;
        w_rsp_valid_nxt   = '0;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_nack_nxt    = r_rsp_nack;
        w_rsp_timeout_nxt = r_rsp_timeout;
        w_m_start_nxt     = 1'b0;
        w_m_abort_nxt     = 1'b0;
        w_grant           = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_any && !bus.m_busy) begin
                    w_grant                = 1'b1;
                    w_state_nxt            = WAIT;
                    w_cnt_nxt              = '0;
                    w_owner_nxt            = w_win;
                    w_req_ready_nxt[w_win] = 1'b1;
                    w_m_start_nxt          = 1'b1;
                    w_cmd_nxt.rw           = bus.req_rw[w_win];
                    w_cmd_nxt.addr         = w_win ? bus.req_addr[2*AW-1:AW]
                                                   : bus.req_addr[AW-1:0];
                    w_cmd_nxt.wdata        = w_win ? bus.req_wdata[2*DW-1:DW]
                                                   : bus.req_wdata[DW-1:0];
                end
            end
            WAIT: begin
                // A done arriving on the timeout cycle still counts as success
                if (bus.m_done) begin
                    w_state_nxt              = RESP;
                    w_rsp_valid_nxt[r_owner] = 1'b1;
                    w_rsp_rdata_nxt          = r_cmd.rw ? bus.m_rdata : '0;
                    w_rsp_nack_nxt           = bus.m_nack;
                    w_rsp_timeout_nxt        = 1'b0;
                end else if (r_cnt == TIMEOUT) begin
                    w_state_nxt              = RESP;
                    w_m_abort_nxt            = 1'b1;
                    w_rsp_valid_nxt[r_owner] = 1'b1;
                    w_rsp_rdata_nxt          = '0;
                    w_rsp_nack_nxt           = 1'b0;
                    w_rsp_timeout_nxt        = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_owner       <= 1'b0;
            r_cmd         <= '0;
            r_req_ready   <= '0;
            r_rsp_valid   <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_nack    <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_m_start     <= 1'b0;
            r_m_abort     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_owner       <= w_owner_nxt;
            r_cmd         <= w_cmd_nxt;
            r_req_ready   <= w_req_ready_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_nack    <= w_rsp_nack_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
            r_m_start     <= w_m_start_nxt;
            r_m_abort     <= w_m_abort_nxt;
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_nack    = r_rsp_nack;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.m_start     = r_m_start;
    assign bus.m_abort     = r_m_abort;
    assign bus.m_rw        = r_cmd.rw;
    assign bus.m_addr      = r_cmd.addr;
    assign bus.m_wdata     = r_cmd.wdata;

endmodule
